mod_exp: RTL

Modular exponentiation engine: computes `base_in ^ exponent_in mod modulus_in` by right-to-left square-and-multiply. It is the initiator side of the ready/busy/valid handshake used by our arithmetic blocks. Every product is issued as a request to an external modular-multiply responder (`a*b mod m`, same handshake), and the engine sequences those requests. It sits above the modular arithmetic units in the key-generation datapath.

---
 rtl/mod_exp.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mod_exp.sv
// Modular exponentiation engine: right-to-left square-and-multiply.
// Every product is requested from an external a*b mod m responder.
module mod_exp #(
   parameter int WIDTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             ready_in,
   input  logic [WIDTH-1:0] base_in,
   input  logic [WIDTH-1:0] exponent_in,
   input  logic [WIDTH-1:0] modulus_in,
   output logic [WIDTH-1:0] result_out,
   output logic             busy_out,
   output logic             valid_out,
   output logic             mul_ready_out,
   output logic [WIDTH-1:0] mul_a_out,
   output logic [WIDTH-1:0] mul_b_out,
   output logic [WIDTH-1:0] mul_modulus_out,
   input  logic             mul_busy_in,
   input  logic             mul_valid_in,
   input  logic [WIDTH-1:0] mul_result_in
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_MUL_REQ,
      S_MUL_WAIT,
      S_SQR_REQ,
      S_SQR_WAIT,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] e_q, e_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             busy_q, busy_d;
   logic             last_busy_q;
   logic             mul_req;

   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
      state_d  = state_q;
      acc_d    = acc_q;
      b_d      = b_q;
      e_d      = e_q;
      m_d      = m_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      result_d = result_q;
      busy_d   = busy_q;
      mul_req  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ready_in && !busy_q) begin
               b_d     = base_in;
               e_d     = exponent_in;
               m_d     = modulus_in;
               acc_d   = WIDTH'(1);
               busy_d  = 1'b1;
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            if (m_q <= WIDTH'(1)) begin
               acc_d   = '0;
               state_d = S_DONE;
            end else if (e_q == '0) begin
               acc_d   = WIDTH'(1);
               state_d = S_DONE;
            end else if (e_q[0]) begin
               op_a_d  = acc_q;
               op_b_d  = b_q;
               state_d = S_MUL_REQ;
            end else begin
               op_a_d  = b_q;
               op_b_d  = b_q;
               state_d = S_SQR_REQ;
            end
         end

         // A request is held back while the responder still reports busy.
         S_MUL_REQ: begin
            if (!mul_busy_in) begin
               mul_req = 1'b1;
               state_d = S_MUL_WAIT;
            end
         end

         S_MUL_WAIT: begin
            if (mul_valid_in) begin
               acc_d = mul_result_in;
               if ((e_q >> 1) == '0) begin
                  state_d = S_DONE;
               end else begin
                  op_a_d  = b_q;
                  op_b_d  = b_q;
                  state_d = S_SQR_REQ;
               end
            end
         end

         S_SQR_REQ: begin
            if (!mul_busy_in) begin
               mul_req = 1'b1;
               state_d = S_SQR_WAIT;
            end
         end

         S_SQR_WAIT: begin
            if (mul_valid_in) begin
               b_d     = mul_result_in;
               e_d     = e_q >> 1;
               state_d = S_CHECK;
            end
         end

         S_DONE: begin
            result_d = acc_q;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
      if (rst_in) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         b_q      <= '0;
         e_q      <= '0;
         m_q      <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         e_q      <= e_d;
         m_q      <= m_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         result_q <= result_d;
         busy_q   <= busy_d;
      end
   end

   // Cleared under reset so no completion pulse follows a reset taken while busy.
   always_ff @(posedge clk_in) begin
      last_busy_q <= rst_in ? 1'b0 : busy_q;
   end

   assign result_out      = result_q;
   assign busy_out        = busy_q;
   assign valid_out       = last_busy_q && !busy_q;
   assign mul_ready_out   = mul_req;
   assign mul_a_out       = op_a_q;
   assign mul_b_out       = op_b_q;
   assign mul_modulus_out = m_q;

endmodule
